i2s_source_scheduler: RTL
=========================

// Module: i2s_source_scheduler
// PURPOSE
//  Frame-synchronous scheduler that shares the single I2S serial output between two serial sources (sd_c1, sd_c2).
//  channel_sel requests are latched and applied only at a left-word boundary, so a word is never torn.
//  Sits between the serial input pins and the output pad stage, clocked by the bit clock.
//  Mute while unsynchronised; auto mode alternates sources every AUTO_FRAMES frames.
// PARAMETERS
//  MAX_BITS     32  longest legal word (sck cycles per ws half-period)
//  MIN_BITS     8   shortest legal word
//  AUTO_FRAMES  4   frames per source in auto mode (>=1)
// PORTS
//  sck          in   1  bit clock; all state on rising edge
//  rst          in   1  reset, asynchronous, active-high
//  ws           in   1  word select (0 = left), I2S timing: changes one bit before MSB
//  sd_c1        in   1  serial data source 1
//  sd_c2        in   1  serial data source 2
//  channel_sel  in   2  00 mute, 01 c1, 10 c2, 11 auto
//  sd_out       out  1  registered scheduled data
//  wsd          out  1  ws delayed one sck (aligned with sd_out)
//  wsp          out  1  ws ^ wsd, word-edge pulse (combinational)
//  active_src   out  2  source currently driving sd_out (00 mute, 01 c1, 10 c2)
//  pending      out  1  registered channel_sel differs from applied mode
//  locked       out  1  FSM in RUN
//  frame_err    out  1  one-cycle pulse, illegal word length
// BEHAVIOUR
//  Reset: sd_out=0, wsd=0, active_src=00, pending=0, locked=0, frame_err=0, bit_cnt=0, frame_cnt=0, state=SYNC.
//  wsd <= ws each edge. frame_start = ws==0 && wsd==1 (left word MSB follows next edge).
//  bit_cnt: cleared to 1 on any wsp edge, else +1, saturating at MAX_BITS+1.
//  Word-length check at each wsp edge (previous word length = bit_cnt):
//   -> if locked and (bit_cnt<MIN_BITS or bit_cnt>MAX_BITS): frame_err=1 for that cycle.
//  Word-length check exemptions: first partial word after leaving SYNC; any edge while state=SYNC.
//  FSM: SYNC -> RUN on first frame_start; RUN -> SYNC on frame_err; SYNC forces active_src=00.
//  Mode change: sel_q <= channel_sel every edge; pending = (sel_q != applied_mode).
//  At frame_start in RUN, or at the SYNC->RUN edge:
//   -> applied_mode <= sel_q; active_src updated per mode.
//   -> entering auto (11 from other): active_src=01, frame_cnt=0.
//  Auto mode: at each frame_start, frame_cnt+1.
//   -> when frame_cnt reaches AUTO_FRAMES-1: frame_cnt=0 and active_src toggles 01<->10.
//  Datapath: sd_out <= mux(active_src_q){0, sd_c1, sd_c2} using pre-update value.
//   -> latency 1 sck, matching wsd.
//   -> the bit sampled on the frame_start edge (previous right LSB) still comes from the old source.
//  Simultaneous: frame_err and frame_start on one edge -> error wins, state=SYNC, active_src=00, no mode apply.
//  channel_sel change on a frame_start edge is not seen until the next frame (sel_q is one edge behind).
//  ws stuck: bit_cnt saturates.
//   -> frame_err fires on the next ws edge, after which the block resyncs.
//  Mid-operation rst: everything returns to reset values immediately, no clock needed.
// STRUCTURE
//  Package i2s_sched_pkg:
//   - src_t: SRC_MUTE=2'b00, SRC_C1=2'b01, SRC_C2=2'b10, SRC_AUTO=2'b11.
//   - state_t: SYNC, RUN.
//   - function cnt_w(MAX_BITS) = $clog2(MAX_BITS+2).
//  Sub-module i2s_ws_tracker: wsd, wsp, frame_start, saturating bit_cnt, length check.
//  Top: FSM, mode/auto scheduling, output mux register.
// TESTING
//  1 rst=1 mid-stream, ws toggling -> all outputs 0 asynchronously, locked=0 until the first ws 1->0.
//  2 sel=01, 16-bit words, sd_c1=0xA5A5 -> sd_out reproduces sd_c1 one sck late, wsd aligned, active_src=01.
//  3 sel 01->10 mid-left-word -> pending=1, switch on the next frame_start.
//     -> right LSB of current frame still from c1; MSB of next left word from c2.
//  4 sel=11, AUTO_FRAMES=4, 8 frames -> frames 1-4 on c1, 5-8 on c2, active_src toggles exactly at frame_start.
//  5 one word of 6 bits (MIN=8) while locked -> frame_err pulse 1 cycle, locked=0, sd_out=0.
//     -> relock and resume at the following frame_start.
//  6 ws held low for 40 sck -> frame_err on the next ws edge, bit_cnt never wraps past MAX_BITS+1.

Source files
------------

// File: rtl/i2s_sched_pkg.sv
// Shared types and sizing helpers for the I2S source scheduler.
package i2s_sched_pkg;

    typedef enum logic [1:0] {
        SRC_MUTE = 2'b00,
        SRC_C1   = 2'b01,
        SRC_C2   = 2'b10,
        SRC_AUTO = 2'b11
    } src_t;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter must hold MAX_BITS+1 so an over-long word stays distinguishable.
    function automatic int unsigned cnt_w(input int unsigned max_bits);
        return $clog2(max_bits + 2);
    endfunction

endpackage

// File: rtl/i2s_source_scheduler_if.sv
// Serial pins and status of the I2S source scheduler.
interface i2s_source_scheduler_if;

    logic       ws;
    logic       sd_c1;
    logic       sd_c2;
    logic [1:0] channel_sel;
    logic       sd_out;
    logic       wsd;
    logic       wsp;
    logic [1:0] active_src;
    logic       pending;
    logic       locked;
    logic       frame_err;

    modport master (
        output ws, sd_c1, sd_c2, channel_sel,
        input  sd_out, wsd, wsp, active_src, pending, locked, frame_err
    );

    modport slave (
        input  ws, sd_c1, sd_c2, channel_sel,
        output sd_out, wsd, wsp, active_src, pending, locked, frame_err
    );

endinterface

// File: rtl/i2s_ws_tracker.sv
// Word-select tracker: delayed ws, word-edge pulse, frame start and
// saturating bit counter used to flag illegal word lengths.
module i2s_ws_tracker
    import i2s_sched_pkg::*;
#(
    parameter int unsigned MAX_BITS = 32,
    parameter int unsigned MIN_BITS = 8
) (
    input  logic sck,
    input  logic rst,
    input  logic ws,
    output logic wsd,
    output logic wsp,
    output logic frame_start_c,
    output logic len_bad_c
);

    localparam int unsigned      CNT_W   = cnt_w(MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);

    logic [CNT_W-1:0] bit_cnt;

    assign wsp           = ws ^ wsd;
    assign frame_start_c = ~ws & wsd;
    // At a word edge bit_cnt still holds the length of the word just ended.
    assign len_bad_c     = wsp & ((bit_cnt < CNT_MIN) | (bit_cnt > CNT_MAX));

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wsd     <= 1'b0;
            bit_cnt <= '0;
        end else begin
            wsd <= ws;
            if (wsp) begin
                bit_cnt <= CNT_W'(1);
            end else if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_source_scheduler.sv
// Frame-synchronous scheduler sharing one I2S serial output between two
// sources; source changes only take effect at a left-word boundary.
module i2s_source_scheduler
    import i2s_sched_pkg::*;
#(
    parameter int unsigned MAX_BITS    = 32,
    parameter int unsigned MIN_BITS    = 8,
    parameter int unsigned AUTO_FRAMES = 4
) (
    input  logic                        sck,
    input  logic                        rst,
    i2s_source_scheduler_if.slave       bus
);

    localparam int unsigned       FCNT_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_FRAMES - 1);

    state_t            state;
    src_t              sel_q;
    src_t              applied_mode;
    src_t              active_q;
    logic [FCNT_W-1:0] frame_cnt;
    logic              sd_out;
    logic              pending;
    logic              frame_err;

    logic wsd;
    logic wsp;
    logic frame_start_c;
    logic len_bad_c;
    logic err_c;
    logic apply_c;
    src_t sel_in_c;

    i2s_ws_tracker #(
        .MAX_BITS (MAX_BITS),
        .MIN_BITS (MIN_BITS)
    ) u_trk (
        .sck           (sck),
        .rst           (rst),
        .ws            (bus.ws),
        .wsd           (wsd),
        .wsp           (wsp),
        .frame_start_c (frame_start_c),
        .len_bad_c     (len_bad_c)
    );

    // A length error outranks a coincident frame start.
    assign err_c    = (state == RUN) & len_bad_c;
    assign apply_c  = frame_start_c & ~err_c;
    assign sel_in_c = src_t'(bus.channel_sel);

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state        <= SYNC;
            sel_q        <= SRC_MUTE;
            applied_mode <= SRC_MUTE;
            active_q     <= SRC_MUTE;
            frame_cnt    <= '0;
            sd_out       <= 1'b0;
            pending      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sel_q     <= sel_in_c;
            frame_err <= err_c;
            pending   <= (sel_in_c != (apply_c ? sel_q : applied_mode));

            // Mux uses the pre-update source so the previous right LSB is not torn.
            case (active_q)
                SRC_C1:  sd_out <= bus.sd_c1;
                SRC_C2:  sd_out <= bus.sd_c2;
                default: sd_out <= 1'b0;
            endcase

            if (err_c) begin
                state     <= SYNC;
                active_q  <= SRC_MUTE;
                frame_cnt <= '0;
            end else if (frame_start_c) begin
                state        <= RUN;
                applied_mode <= sel_q;
                if (sel_q != SRC_AUTO) begin
                    active_q  <= sel_q;
                    frame_cnt <= '0;
                end else if (state == SYNC || applied_mode != SRC_AUTO) begin
                    active_q  <= SRC_C1;
                    frame_cnt <= '0;
                end else if (frame_cnt == FCNT_LAST) begin
                    frame_cnt <= '0;
                    active_q  <= (active_q == SRC_C1) ? SRC_C2 : SRC_C1;
                end else begin
                    frame_cnt <= frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

    assign bus.sd_out     = sd_out;
    assign bus.wsd        = wsd;
    assign bus.wsp        = wsp;
    assign bus.active_src = active_q;
    assign bus.pending    = pending;
    assign bus.locked     = (state == RUN);
    assign bus.frame_err  = frame_err;

endmodule
